// File: rtl/axi_mem_if_pkg.sv
// Shared encodings for the AXI memory-port arbiter: priority values and
// active-low SRAM strobe levels.
package axi_mem_if_pkg;

    localparam logic PRIO_WR   = 1'b0;
    localparam logic PRIO_RD   = 1'b1;

    localparam logic MEM_EN    = 1'b0;
    localparam logic MEM_WRITE = 1'b0;

endpackage

// File: rtl/axi_mem_rd_latency_pipe.sv
// Tracks issued SRAM reads through the macro latency; the last stage marks
// the cycle on which Q is valid. Synchronous clear drops in-flight reads.
module axi_mem_rd_latency_pipe #(
    parameter int STAGES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic qvalid
);

    logic [STAGES:1] vld_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= issue;
            for (int i = 2; i <= STAGES; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign qvalid = vld_pipe[STAGES];

endmodule

// File: rtl/axi_mem_port_arbiter.sv
// Round-robin arbiter muxing the AXI write and read controllers onto one
// single-port SRAM, with read-return valid tracking.
module axi_mem_port_arbiter
    import axi_mem_if_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 64,
    parameter int NUMBYTES       = DATA_WIDTH / 8,
    parameter int MEM_LATENCY    = 1
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      WR_valid_i,
    output logic                      WR_grant_o,
    input  logic                      WR_CEN_i,
    input  logic                      WR_WEN_i,
    input  logic [MEM_ADDR_WIDTH-1:0] WR_A_i,
    input  logic [DATA_WIDTH-1:0]     WR_D_i,
    input  logic [NUMBYTES-1:0]       WR_BE_i,

    input  logic                      RD_valid_i,
    output logic                      RD_grant_o,
    input  logic                      RD_CEN_i,
    input  logic [MEM_ADDR_WIDTH-1:0] RD_A_i,
    output logic [DATA_WIDTH-1:0]     RD_Q_o,
    output logic                      RD_QVALID_o,

    output logic                      MEM_CEN_o,
    output logic                      MEM_WEN_o,
    output logic [MEM_ADDR_WIDTH-1:0] MEM_A_o,
    output logic [DATA_WIDTH-1:0]     MEM_D_o,
    output logic [NUMBYTES-1:0]       MEM_BE_o,
    input  logic [DATA_WIDTH-1:0]     MEM_Q_i
);

    logic prio;
    logic wr_gnt;
    logic rd_gnt;
    logic rd_issue;

    always_comb begin
        wr_gnt = WR_valid_i & (~RD_valid_i | (prio == PRIO_WR));
        rd_gnt = RD_valid_i & (~WR_valid_i | (prio == PRIO_RD));
    end

    // Priority moves to the loser of every contended cycle, even if the winner
    // idled (CEN high), so a stalled burst cannot starve the other side.
    always_ff @(posedge clk) begin
        if (rst)
            prio <= PRIO_WR;
        else if (WR_valid_i && RD_valid_i)
            prio <= wr_gnt ? PRIO_RD : PRIO_WR;
    end

    always_comb begin
        MEM_CEN_o = ~MEM_EN;
        MEM_WEN_o = ~MEM_WRITE;
        MEM_A_o   = WR_A_i;
        MEM_D_o   = WR_D_i;
        MEM_BE_o  = WR_BE_i;
        if (wr_gnt) begin
            MEM_CEN_o = WR_CEN_i;
            MEM_WEN_o = WR_WEN_i;
        end else if (rd_gnt) begin
            MEM_CEN_o = RD_CEN_i;
            MEM_A_o   = RD_A_i;
            MEM_D_o   = '0;
            MEM_BE_o  = '1;
        end
    end

    assign WR_grant_o = wr_gnt;
    assign RD_grant_o = rd_gnt;
    assign rd_issue   = rd_gnt & (RD_CEN_i == MEM_EN);
    assign RD_Q_o     = MEM_Q_i;

    axi_mem_rd_latency_pipe #(
        .STAGES (MEM_LATENCY)
    ) u_rd_pipe (
        .clk    (clk),
        .rst    (rst),
        .issue  (rd_issue),
        .qvalid (RD_QVALID_o)
    );

endmodule

// File: tb/tb_axi_mem_port_arbiter.sv
// Directed bench: three arbiter instances (latency 1, 2, 3) share stimulus;
// a per-instance queue of expected QVALID cycles is checked every cycle.
module tb_axi_mem_port_arbiter;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int NDUT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid, wr_cen, wr_wen;
    logic [AW-1:0] wr_a;
    logic [DW-1:0] wr_d;
    logic [BW-1:0] wr_be;
    logic          rd_valid, rd_cen;
    logic [AW-1:0] rd_a;
    logic [DW-1:0] mem_q;

    logic          wr_gnt  [NDUT];
    logic          rd_gnt  [NDUT];
    logic [DW-1:0] rd_q    [NDUT];
    logic          qvalid  [NDUT];
    logic          mem_cen [NDUT];
    logic          mem_wen [NDUT];
    logic [AW-1:0] mem_a   [NDUT];
    logic [DW-1:0] mem_d   [NDUT];
    logic [BW-1:0] mem_be  [NDUT];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    logic m_prio;
    int exp_q [NDUT][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        axi_mem_port_arbiter #(
            .MEM_ADDR_WIDTH (AW),
            .DATA_WIDTH     (DW),
            .NUMBYTES       (BW),
            .MEM_LATENCY    (g + 1)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .WR_valid_i  (wr_valid),
            .WR_grant_o  (wr_gnt[g]),
            .WR_CEN_i    (wr_cen),
            .WR_WEN_i    (wr_wen),
            .WR_A_i      (wr_a),
            .WR_D_i      (wr_d),
            .WR_BE_i     (wr_be),
            .RD_valid_i  (rd_valid),
            .RD_grant_o  (rd_gnt[g]),
            .RD_CEN_i    (rd_cen),
            .RD_A_i      (rd_a),
            .RD_Q_o      (rd_q[g]),
            .RD_QVALID_o (qvalid[g]),
            .MEM_CEN_o   (mem_cen[g]),
            .MEM_WEN_o   (mem_wen[g]),
            .MEM_A_o     (mem_a[g]),
            .MEM_D_o     (mem_d[g]),
            .MEM_BE_o    (mem_be[g]),
            .MEM_Q_i     (mem_q)
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Read returns: QVALID must be high exactly on the queued cycles.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < NDUT; d++) begin
                bit exp_v;
                exp_v = (exp_q[d].size() > 0) && (exp_q[d][0] == cyc);
                if (exp_v) void'(exp_q[d].pop_front());
                chk($sformatf("qvalid[lat%0d]", d + 1), 64'(qvalid[d]), 64'(exp_v));
                if (exp_v) chk($sformatf("rd_q[lat%0d]", d + 1), rd_q[d], mem_q);
            end
        end
    end

    // One cycle of stimulus; expected grants and SRAM port come from a prio model.
    task automatic step(input logic r,
                        input logic wv, input logic wc, input logic ww,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [BW-1:0] wb,
                        input logic rv, input logic rc, input logic [AW-1:0] ra);
        logic eg_w, eg_r, e_cen, e_wen;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        logic [BW-1:0] e_be;
        rst = r; wr_valid = wv; wr_cen = wc; wr_wen = ww; wr_a = wa; wr_d = wd;
        wr_be = wb; rd_valid = rv; rd_cen = rc; rd_a = ra;
        mem_q = {32'hC0DE_0000, 32'(cyc)};
        eg_w = wv && (!rv || m_prio == 1'b0);
        eg_r = rv && (!wv || m_prio == 1'b1);
        e_cen = 1'b1; e_wen = 1'b1; e_a = wa; e_d = wd; e_be = wb;
        if (eg_w) begin
            e_cen = wc; e_wen = ww;
        end else if (eg_r) begin
            e_cen = rc; e_a = ra; e_d = '0; e_be = '1;
        end
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("wr_grant[lat%0d]", d + 1), 64'(wr_gnt[d]), 64'(eg_w));
            chk($sformatf("rd_grant[lat%0d]", d + 1), 64'(rd_gnt[d]), 64'(eg_r));
        end
        chk("mem_cen", 64'(mem_cen[0]), 64'(e_cen));
        chk("mem_wen", 64'(mem_wen[0]), 64'(e_wen));
        chk("mem_a",   64'(mem_a[0]),   64'(e_a));
        chk("mem_d",   mem_d[0],        e_d);
        chk("mem_be",  64'(mem_be[0]),  64'(e_be));
        if (r) begin
            m_prio = 1'b0;
            for (int d = 0; d < NDUT; d++)
                while (exp_q[d].size() > 0 && exp_q[d][exp_q[d].size()-1] > cyc)
                    void'(exp_q[d].pop_back());
        end else begin
            if (wv && rv) m_prio = eg_w ? 1'b1 : 1'b0;
            if (eg_r && !rc)
                for (int d = 0; d < NDUT; d++) exp_q[d].push_back(cyc + d + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 1, '0, '0, '0, 0, 1, '0);
    endtask

    initial begin
        m_prio = 1'b0;
        rst = 1'b1; wr_valid = 0; wr_cen = 1; wr_wen = 1; wr_a = '0; wr_d = '0;
        wr_be = '0; rd_valid = 0; rd_cen = 1; rd_a = '0; mem_q = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        step(1, 0, 1, 1, '0, '0, '0, 0, 1, '0);
        step(1, 0, 1, 1, '0, '0, '0, 0, 1, '0);
        idle(1);

        // Write only
        step(0, 1, 0, 0, 13'h010, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 1, '0);
        idle(3);

        // Read only
        step(0, 0, 1, 1, '0, '0, '0, 1, 0, 13'h020);
        idle(4);

        // Contended from reset: WR, RD, WR, RD
        step(1, 0, 1, 1, '0, '0, '0, 0, 1, '0);
        for (int i = 0; i < 4; i++)
            step(0, 1, 0, 0, 13'(16 + i), 64'(i), 8'h0F, 1, 0, 13'(32 + i));
        idle(4);

        // Stalled write burst holding valid while reads are pending
        for (int i = 0; i < 4; i++)
            step(0, 1, 1, 0, 13'h055, 64'h1234, 8'hF0, 1, 0, 13'(64 + i));
        idle(4);

        // Three back-to-back reads
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 1, '0, '0, '0, 1, 0, 13'(100 + i));
        idle(5);

        // Read-granted cycle with CEN high is an idle SRAM cycle
        step(0, 0, 1, 1, '0, '0, '0, 1, 1, 13'h0AA);
        idle(3);

        // Leave prio on read, issue a read, then reset one cycle later
        step(0, 1, 0, 0, 13'h001, 64'h5, 8'hFF, 1, 0, 13'h002);
        idle(4);
        step(0, 0, 1, 1, '0, '0, '0, 1, 0, 13'h0BB);
        step(1, 0, 1, 1, '0, '0, '0, 0, 1, '0);
        step(0, 1, 0, 0, 13'h003, 64'h7, 8'hFF, 1, 0, 13'h004);
        idle(5);

        for (int d = 0; d < NDUT; d++)
            chk($sformatf("drained[lat%0d]", d + 1), 64'(exp_q[d].size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_mem_port_arbiter.md
Name: axi_mem_port_arbiter

Overview:
- Sits directly downstream of the AXI write-only and read-only memory controllers, between them and one single-port SRAM macro.
- Arbitrates their per-beat memory requests round-robin and multiplexes the winner's control, address and data onto the SRAM port.
- Tracks issued reads through the SRAM latency and returns Q with a valid strobe to the read controller.

Parameters:
- MEM_ADDR_WIDTH, 13, SRAM word-address width.
- DATA_WIDTH, 64, SRAM data width.
- NUMBYTES, DATA_WIDTH/8, byte-enable width.
- MEM_LATENCY, 1, cycles from SRAM access to Q valid (1..4).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- WR_valid_i  in  1  write ctrl requests the port this cycle
- WR_grant_o  out  1  write ctrl owns the port this cycle
- WR_CEN_i  in  1  write ctrl chip enable, active-low
- WR_WEN_i  in  1  write ctrl write enable, active-low
- WR_A_i  in  MEM_ADDR_WIDTH  write address
- WR_D_i  in  DATA_WIDTH  write data
- WR_BE_i  in  NUMBYTES  write byte enables
- RD_valid_i  in  1  read ctrl requests the port
- RD_grant_o  out  1  read ctrl owns the port
- RD_CEN_i  in  1  read ctrl chip enable, active-low
- RD_A_i  in  MEM_ADDR_WIDTH  read address
- RD_Q_o  out  DATA_WIDTH  read data
- RD_QVALID_o  out  1  RD_Q_o valid
- MEM_CEN_o  out  1  SRAM chip enable, active-low
- MEM_WEN_o  out  1  SRAM write enable, active-low (0 = write)
- MEM_A_o  out  MEM_ADDR_WIDTH  SRAM address
- MEM_D_o  out  DATA_WIDTH  SRAM write data
- MEM_BE_o  out  NUMBYTES  SRAM byte enables
- MEM_Q_i  in  DATA_WIDTH  SRAM read data

Behaviour:
- One clock domain (clk); reset rst is synchronous and active-high.
- Grants are combinational from the valids in the same cycle. Upstream controllers gate their CEN with grant in the same cycle.
- Only one requester valid: that requester is granted.
- Both valid: the requester holding priority is granted.
- Priority register prio: 0 = write first, 1 = read first. Reset value 0.
- prio updates only on a contended cycle (both valid). It is set to the loser of that cycle, whether or not the winner's CEN was low. This prevents a stalled burst that holds valid from starving the other side.
- No valid: both grants 0, MEM_CEN_o = 1, MEM_WEN_o = 1, and A/D/BE are driven from the write side to avoid toggling.
- Write granted:
  - MEM_CEN_o = WR_CEN_i, MEM_WEN_o = WR_WEN_i.
  - MEM_A_o, MEM_D_o and MEM_BE_o come from the WR_* inputs.
- Read granted:
  - MEM_CEN_o = RD_CEN_i, MEM_WEN_o = 1, MEM_A_o = RD_A_i.
  - MEM_D_o = 0, MEM_BE_o = all ones.
- Read issue = RD_grant_o & ~RD_CEN_i.
  - The issue bit shifts through an MEM_LATENCY-deep register chain.
  - RD_QVALID_o = last stage of the chain.
  - RD_Q_o = MEM_Q_i, passed through combinationally.
- Back-to-back reads give back-to-back QVALID. No internal buffering; the read ctrl must accept Q when QVALID is high.
- Reset mid-operation: prio is set to 0 and the read pipeline is cleared. In-flight read returns are discarded, so QVALID = 0 on the cycle after rst.
- A granted cycle with CEN = 1 passes through as an idle SRAM cycle. No error is flagged.
- Reset values: RD_QVALID_o = 0. Grants follow the valids (combinational), including during reset, with prio = 0.

Decomposition:
- Package axi_mem_if_pkg holds:
  - prio encoding constants PRIO_WR = 1'b0 and PRIO_RD = 1'b1.
  - active-low constants MEM_EN = 1'b0 and MEM_WRITE = 1'b0.
- One natural sub-module: axi_mem_rd_latency_pipe, the MEM_LATENCY-deep valid shift chain with synchronous clear.
- The arbiter and mux stay in the top module.

Test Plan:
- Write only, WR_valid = 1, WR_CEN = 0, WR_A = 0x010, WR_D = 0xDEAD_BEEF_0000_0001 -> WR_grant = 1 the same cycle, MEM_WEN = 0, MEM_A = 0x010; RD_QVALID stays 0.
- Read only, RD_A = 0x020, MEM_LATENCY = 1 -> RD_grant = 1, MEM_WEN = 1; RD_QVALID = 1 exactly one cycle later with RD_Q = MEM_Q_i.
- Both valid for 4 cycles from reset -> grants go WR, RD, WR, RD; prio toggles each cycle.
- Write burst stalled (WR_valid = 1, WR_CEN = 1) while a read is pending -> read granted on alternate cycles; the stalled write cycle puts MEM_CEN = 1.
- MEM_LATENCY = 3 with 3 consecutive reads -> QVALID high on cycles 3, 4 and 5 after the first issue.
- rst asserted 1 cycle after a read issue with MEM_LATENCY = 2 -> QVALID never asserts for that read; prio = 0 after reset, so the next contended cycle grants write.
